interval_meter: RTL
===================

Name: interval_meter

Overview:
- Measuring counterpart of the alarm/timeout/pulse timers. Those timers take a loaded count and produce an event; this block takes events on `in` and reports the clock-cycle count between two rising edges.
- Result is presented as `value` plus a one-cycle `put` strobe, the same value/put pairing the timers consume, so a measured interval can be fed straight back into a timer.
- Sits beside the timer blocks on the same clock domain.

Parameters:
- W, 8, width of counter and `value`.
- CONT, 0: 0 = single-shot (one measurement per `arm`); 1 = continuous (every further rising edge closes one period and opens the next).

Ports:
- clock  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle request to start (or restart) a measurement.
- in  in  1  measured signal, synchronous to `clock`.
- value  out  W  last measured interval in clock cycles; held until the next `put`.
- put  out  1  one-cycle strobe: `value`/`ovf` updated this cycle.
- ovf  out  1  last measurement saturated; valid with `value`.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, value=0, put=0, ovf=0, busy=0, count=0, prev=0. Reset mid-measurement aborts with no `put`.
- Edge detect: `edge = in & ~prev`, where `prev` is `in` registered every cycle. Only low-to-high transitions sampled on consecutive clocks count. An `in` already high when armed gives no edge until it goes low, then high again.
- States: IDLE, WAIT (armed, waiting for the first edge), MEASURE (counting).
- IDLE: `arm` -> WAIT. Edges are ignored.
- WAIT: `edge` -> MEASURE, count <= 0.
- MEASURE: each cycle without `edge`, count <= count+1, saturating at 2^W-1.
- MEASURE on `edge`:
  - value <= sat(count+1), ovf <= (count+1 >= 2^W-1 overflowed, i.e. count was already 2^W-1), put <= 1 for one cycle.
  - CONT=0: next state IDLE.
  - CONT=1: stay in MEASURE with count <= 0; this edge opens the next period.
- Result: edges sampled at cycles t0 and t1 give value = t1-t0. Registered outputs appear in cycle t1+1. Minimum reportable interval is 2 (pattern 1,0,1).
- Saturation: the count stops at 2^W-1. A measurement ending while saturated reports value = 2^W-1 with ovf=1. An interval of exactly 2^W-1 reports ovf=0. There is no timeout: MEASURE waits indefinitely.
- `arm` has priority in every state. In WAIT or MEASURE it aborts (no `put`) and enters WAIT. An edge in the same cycle as `arm` is ignored, including the cycle that would have closed a measurement.
- `put` is high for exactly one cycle per completed measurement. `value` and `ovf` change only together with `put`.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Basic, CONT=0, W=8: reset low at 10 ns, release at 23 ns; `arm` at cycle 5; `in` rises at cycles 10 and 35 -> cycle 36: put=1 for one cycle, value=8'h19, ovf=0, busy=0; later edges produce no `put`.
- Overflow: rising edges 300 cycles apart -> value=8'hFF, ovf=1. Edges 255 apart -> value=8'hFF, ovf=0. Edges 254 apart -> value=8'hFE.
- Re-arm abort: `arm`, first edge at cycle 10, `arm` again at cycle 20, edges at cycles 30 and 42 -> a single `put` with value=12. An edge coinciding with `arm` is not counted.
- Continuous, CONT=1: `in` pulses high one cycle every 10 cycles after `arm` -> `put` every 10 cycles with value=10; busy stays 1.
- Edge cases: `in` held high across `arm`, then pattern 0,1,0,1 -> value=2. `in` high for several cycles counts a single edge.
- Async reset: assert reset=0 mid-MEASURE, between clock edges -> outputs go to 0 immediately with no `put`. After release, busy=0 until the next `arm`.

Source files
------------

// File: rtl/interval_meter.sv
// Measures the clock-cycle interval between two rising edges of `in`.
// The result comes out as a value/put pair, so it can feed a timer directly.
module interval_meter #(
  parameter int W    = 8,
  parameter bit CONT = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         arm,
  input  logic         in,
  output logic [W-1:0] value,
  output logic         put,
  output logic         ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [W-1:0] MAXC = '1;

  state_t         state_reg, state_next;
  logic [W-1:0]   count_reg, count_next;
  logic [W-1:0]   value_reg, value_next;
  logic           ovf_reg, ovf_next;
  logic           put_reg, put_next;
  logic           busy_reg, busy_next;
  logic           prev_reg;
  logic           rise;

  assign rise = in & ~prev_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    value_next = value_reg;
    ovf_next   = ovf_reg;
    put_next   = 1'b0;
    // arm wins over everything, including an edge that would close a period
    if (arm) begin
      state_next = WAIT;
    end else begin
      case (state_reg)
        IDLE: begin
        end
        WAIT: begin
          if (rise) begin
            state_next = MEASURE;
            count_next = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            value_next = (count_reg == MAXC) ? MAXC : count_reg + 1'b1;
            ovf_next   = (count_reg == MAXC);
            put_next   = 1'b1;
            if (CONT) begin
              count_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else if (count_reg != MAXC) begin
            count_next = count_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      value_reg <= '0;
      ovf_reg   <= 1'b0;
      put_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      value_reg <= value_next;
      ovf_reg   <= ovf_next;
      put_reg   <= put_next;
      busy_reg  <= busy_next;
      prev_reg  <= in;
    end
  end

  assign value = value_reg;
  assign put   = put_reg;
  assign ovf   = ovf_reg;
  assign busy  = busy_reg;

endmodule
